exu_dbus_bridge: RTL and testbench

//   Data-side bus bridge directly downstream of the execute unit's memory port.

---
 rtl/exu_dbus_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_exu_dbus_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_dbus_bridge.sv
// -----------------------------------------------------------------------------
// exu_dbus_bridge
//
// Data-side bridge between the execute unit's req/gnt/rvalid memory port and an
// AXI4-Lite-style bus. Each granted access becomes exactly one bus transaction:
// AW/W/B for stores, AR/R for loads. Only one transaction is in flight at a time.
// A per-transaction timeout turns a silent slave into a bus error so the pipeline
// never hangs.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed per transaction before abort (0 = disabled)
//   CNT_W           timeout counter width, must hold TIMEOUT_CYCLES
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_req_i .. mem_wdata_i   EXU request (held until granted)
//   mem_gnt_o                  combinational grant, only in IDLE
//   mem_rvalid_o/rdata/err     one-cycle completion pulse with load data / error
//   busy_o                     transaction in flight
//   aw*/w*/b*                  write address / data / response channels
//   ar*/r*                     read address / data channels
// -----------------------------------------------------------------------------
module exu_dbus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  // EXU side
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_err_o,
  output logic        busy_o,
  // write address channel
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  // write data channel
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  // write response channel
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i,
  // read address channel
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  // read data channel
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  // Counter value on the last allowed cycle of a transaction.
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  logic              timeout_hit;
  logic              resp_done;
  logic              abort;

  // Accesses are word-aligned on the bus; the byte offset is carried by be.
  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^mem_addr_i[1:0];

  assign mem_gnt_o = mem_req_i & (state == IDLE);
  assign busy_o    = (state != IDLE);

  // Request fields are held in registers, so they cannot move while a valid is up.
  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = be_q;

  // A response landing on the final allowed cycle still counts as a completion.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
    resp_done   = ((state == RD_RESP) && rvalid_i) || ((state == WR_RESP) && bvalid_i);
    abort       = (state inside {RD_REQ, RD_RESP, WR_REQ, WR_RESP}) && timeout_hit && !resp_done;
  end

  // All bus-facing valid/ready outputs are registered and set from the state being
  // entered, so no ready/valid input reaches a valid/ready output combinationally.
  // rready_o/bready_o stay high in IDLE and DONE to soak up late responses from an
  // aborted or reset-abandoned transaction.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      mem_rvalid_o <= 1'b0;
      mem_rdata_o  <= '0;
      mem_err_o    <= 1'b0;
      awvalid_o    <= 1'b0;
      wvalid_o     <= 1'b0;
      bready_o     <= 1'b0;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
    end else begin
      mem_rvalid_o <= 1'b0;
      if (state != IDLE && state != DONE) begin
        cnt <= cnt + 1'b1;
      end

      if (abort) begin
        arvalid_o    <= 1'b0;
        awvalid_o    <= 1'b0;
        wvalid_o     <= 1'b0;
        rready_o     <= 1'b1;
        bready_o     <= 1'b1;
        mem_err_o    <= 1'b1;
        mem_rdata_o  <= '0;
        mem_rvalid_o <= 1'b1;
        state        <= DONE;
      end else begin
        case (state)
          IDLE: begin
            if (mem_req_i) begin
              addr_q   <= {mem_addr_i[31:2], 2'b00};
              wdata_q  <= mem_wdata_i;
              be_q     <= mem_be_i;
              cnt      <= '0;
              rready_o <= 1'b0;
              bready_o <= 1'b0;
              if (mem_we_i) begin
                awvalid_o <= 1'b1;
                wvalid_o  <= 1'b1;
                state     <= WR_REQ;
              end else begin
                arvalid_o <= 1'b1;
                state     <= RD_REQ;
              end
            end else begin
              rready_o <= 1'b1;
              bready_o <= 1'b1;
            end
          end

          RD_REQ: begin
            if (arready_i) begin
              arvalid_o <= 1'b0;
              rready_o  <= 1'b1;
              state     <= RD_RESP;
            end
          end

          RD_RESP: begin
            if (rvalid_i) begin
              mem_rdata_o  <= rdata_i;
              mem_err_o    <= (rresp_i != 2'b00);
              mem_rvalid_o <= 1'b1;
              bready_o     <= 1'b1;
              state        <= DONE;
            end
          end

          WR_REQ: begin
            // A deasserted valid means that channel's handshake already happened.
            if (awvalid_o && awready_i) awvalid_o <= 1'b0;
            if (wvalid_o && wready_i)   wvalid_o  <= 1'b0;
            if ((!awvalid_o || awready_i) && (!wvalid_o || wready_i)) begin
              bready_o <= 1'b1;
              state    <= WR_RESP;
            end
          end

          WR_RESP: begin
            if (bvalid_i) begin
              mem_rdata_o  <= '0;
              mem_err_o    <= (bresp_i != 2'b00);
              mem_rvalid_o <= 1'b1;
              rready_o     <= 1'b1;
              state        <= DONE;
            end
          end

          DONE: begin
            mem_rdata_o <= '0;
            mem_err_o   <= 1'b0;
            state       <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exu_dbus_bridge.sv
// -----------------------------------------------------------------------------
// tb_exu_dbus_bridge
//
// Directed bench for exu_dbus_bridge with an 8-cycle timeout. A single linear
// sequence of cycle-exact steps drives the EXU port and plays the bus slave by
// hand; expected values are written out as constants for each step.
// -----------------------------------------------------------------------------
module tb_exu_dbus_bridge;

  logic        clk;
  logic        rst_n;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_wdata_i;
  logic        mem_gnt_o;
  logic        mem_rvalid_o;
  logic [31:0] mem_rdata_o;
  logic        mem_err_o;
  logic        busy_o;
  logic        awvalid_o;
  logic        awready_i;
  logic [31:0] awaddr_o;
  logic        wvalid_o;
  logic        wready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        bvalid_i;
  logic        bready_o;
  logic [1:0]  bresp_i;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] araddr_o;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;

  int checks   = 0;
  int failures = 0;

  exu_dbus_bridge #(
    .TIMEOUT_CYCLES(8),
    .CNT_W         (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_be_i    (mem_be_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_gnt_o   (mem_gnt_o),
    .mem_rvalid_o(mem_rvalid_o),
    .mem_rdata_o (mem_rdata_o),
    .mem_err_o   (mem_err_o),
    .busy_o      (busy_o),
    .awvalid_o   (awvalid_o),
    .awready_i   (awready_i),
    .awaddr_o    (awaddr_o),
    .wvalid_o    (wvalid_o),
    .wready_i    (wready_i),
    .wdata_o     (wdata_o),
    .wstrb_o     (wstrb_o),
    .bvalid_i    (bvalid_i),
    .bready_o    (bready_o),
    .bresp_i     (bresp_i),
    .arvalid_o   (arvalid_o),
    .arready_i   (arready_i),
    .araddr_o    (araddr_o),
    .rvalid_i    (rvalid_i),
    .rready_o    (rready_o),
    .rdata_i     (rdata_i),
    .rresp_i     (rresp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Advance to just after the next rising edge; inputs driven now reach the
  // following edge, registered outputs are settled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational grant settle after an input change, away from the edge.
  task automatic settle();
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {30'd0, mem_gnt_o, mem_rvalid_o, mem_err_o, busy_o,
            awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o,
            (|mem_rdata_o), (|awaddr_o), (|wdata_o), (|wstrb_o), (|araddr_o)};
  endfunction

  initial begin
    rst_n       = 1'b0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_be_i    = '0;
    mem_wdata_i = '0;
    awready_i   = 1'b0;
    wready_i    = 1'b0;
    bvalid_i    = 1'b0;
    bresp_i     = '0;
    arready_i   = 1'b0;
    rvalid_i    = 1'b0;
    rdata_i     = '0;
    rresp_i     = '0;

    // ---------------- reset ----------------
    #12;
    check("reset_outputs", all_outs(), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("idle_rready_bready", {62'd0, rready_o, bready_o}, 64'h3);
    check("idle_not_busy", {63'd0, busy_o}, 64'd0);

    // ---------------- zero-wait load ----------------
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_1004; mem_be_i = 4'hF;
    settle();
    check("ld_gnt_T", {63'd0, mem_gnt_o}, 64'd1);
    cyc();                                                     // T+1
    mem_req_i = 1'b0;
    check("ld_arvalid_T1", {62'd0, arvalid_o, busy_o}, 64'h3);
    check("ld_araddr", {32'd0, araddr_o}, 64'h0000_1004);
    check("ld_rready_low_in_req", {63'd0, rready_o}, 64'd0);
    arready_i = 1'b1;
    cyc();                                                     // T+2
    arready_i = 1'b0;
    check("ld_ar_done_T2", {62'd0, arvalid_o, rready_o}, 64'h1);
    rvalid_i = 1'b1; rdata_i = 32'hDEAD_BEEF; rresp_i = 2'b00;
    cyc();                                                     // T+3
    rvalid_i = 1'b0;
    check("ld_rvalid_T3", {63'd0, mem_rvalid_o}, 64'd1);
    check("ld_rdata", {32'd0, mem_rdata_o}, 64'hDEAD_BEEF);
    check("ld_err", {63'd0, mem_err_o}, 64'd0);
    cyc();                                                     // T+4
    check("ld_pulse_one_cycle", {62'd0, mem_rvalid_o, busy_o}, 64'd0);

    // ---------------- store with staggered readies ----------------
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_2002;
    mem_be_i = 4'b1100; mem_wdata_i = 32'h1234_0000;
    settle();
    check("st_gnt_T", {63'd0, mem_gnt_o}, 64'd1);
    cyc();                                                     // T+1
    mem_req_i = 1'b0;
    check("st_valids_T1", {62'd0, awvalid_o, wvalid_o}, 64'h3);
    check("st_awaddr", {32'd0, awaddr_o}, 64'h0000_2000);
    check("st_wstrb", {60'd0, wstrb_o}, 64'hC);
    check("st_wdata", {32'd0, wdata_o}, 64'h1234_0000);
    awready_i = 1'b1;
    cyc();                                                     // T+2
    awready_i = 1'b0;
    check("st_aw_drop_T2", {62'd0, awvalid_o, wvalid_o}, 64'h1);
    cyc();                                                     // T+3
    check("st_w_held_T3", {62'd0, wvalid_o, bready_o}, 64'h2);
    wready_i = 1'b1;
    cyc();                                                     // T+4
    wready_i = 1'b0;
    check("st_w_drop_T4", {61'd0, awvalid_o, wvalid_o, bready_o}, 64'h1);
    bvalid_i = 1'b1; bresp_i = 2'b00;
    cyc();                                                     // T+5
    bvalid_i = 1'b0;
    check("st_rvalid_T5", {63'd0, mem_rvalid_o}, 64'd1);
    check("st_err_rdata", {mem_rdata_o, 31'd0, mem_err_o}, 64'd0);
    cyc();

    // ---------------- load with error response ----------------
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_3000;
    cyc();                                                     // T+1
    mem_req_i = 1'b0;
    arready_i = 1'b1;
    cyc();                                                     // T+2
    arready_i = 1'b0;
    rvalid_i = 1'b1; rdata_i = 32'h0000_0055; rresp_i = 2'b10;
    cyc();                                                     // T+3
    rvalid_i = 1'b0; rresp_i = 2'b00;
    check("lderr_rvalid_err", {62'd0, mem_rvalid_o, mem_err_o}, 64'h3);
    cyc();

    // ---------------- timeout: arready never comes ----------------
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_4000;
    settle();
    check("to_gnt", {63'd0, mem_gnt_o}, 64'd1);
    cyc();                                                     // T+1
    mem_req_i = 1'b0;
    check("to_arvalid_T1", {63'd0, arvalid_o}, 64'd1);
    for (int i = 2; i <= 8; i++) begin
      cyc();                                                   // T+2 .. T+8
      check("to_arvalid_hold", {63'd0, arvalid_o}, 64'd1);
    end
    cyc();                                                     // T+9
    check("to_abort_valids", {63'd0, arvalid_o}, 64'd0);
    check("to_abort_pulse", {62'd0, mem_rvalid_o, mem_err_o}, 64'h3);
    check("to_abort_rdata", {32'd0, mem_rdata_o}, 64'd0);
    cyc();                                                     // T+10, IDLE
    check("to_idle_rready", {62'd0, rready_o, busy_o}, 64'h2);
    rvalid_i = 1'b1; rdata_i = 32'h0000_0099; rresp_i = 2'b00;
    cyc();                                                     // late response consumed
    rvalid_i = 1'b0;
    check("to_stray_no_rvalid", {62'd0, mem_rvalid_o, busy_o}, 64'd0);
    cyc();
    check("to_stray_no_rvalid2", {63'd0, mem_rvalid_o}, 64'd0);

    // ---------------- back-to-back loads, req held ----------------
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_5000;
    settle();
    check("b2b_gnt1", {63'd0, mem_gnt_o}, 64'd1);
    cyc();                                                     // T+1
    mem_addr_i = 32'h0000_5004;
    settle();
    check("b2b_no_gnt_busy", {63'd0, mem_gnt_o}, 64'd0);
    check("b2b_araddr1", {32'd0, araddr_o}, 64'h0000_5000);
    arready_i = 1'b1;
    cyc();                                                     // T+2
    arready_i = 1'b0;
    rvalid_i = 1'b1; rdata_i = 32'hA5A5_0001;
    cyc();                                                     // T+3, DONE
    rvalid_i = 1'b0;
    settle();
    check("b2b_rvalid1", {31'd0, mem_rvalid_o, mem_rdata_o}, {31'd0, 1'b1, 32'hA5A5_0001});
    check("b2b_no_gnt_in_done", {63'd0, mem_gnt_o}, 64'd0);
    cyc();                                                     // T+4, IDLE
    settle();
    check("b2b_gnt2", {62'd0, mem_gnt_o, mem_rvalid_o}, 64'h2);
    cyc();                                                     // T+5
    mem_req_i = 1'b0;
    check("b2b_araddr2", {31'd0, arvalid_o, araddr_o}, {31'd0, 1'b1, 32'h0000_5004});
    arready_i = 1'b1;
    cyc();
    arready_i = 1'b0;
    rvalid_i = 1'b1; rdata_i = 32'hA5A5_0002;
    cyc();
    rvalid_i = 1'b0;
    check("b2b_rvalid2", {31'd0, mem_rvalid_o, mem_rdata_o}, {31'd0, 1'b1, 32'hA5A5_0002});
    cyc();

    // ---------------- reset during WR_RESP ----------------
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_6000;
    mem_be_i = 4'hF; mem_wdata_i = 32'hCAFE_0000;
    cyc();                                                     // T+1
    mem_req_i = 1'b0;
    awready_i = 1'b1; wready_i = 1'b1;
    cyc();                                                     // T+2, WR_RESP
    awready_i = 1'b0; wready_i = 1'b0;
    check("rst_pre_wr_resp", {62'd0, bready_o, busy_o}, 64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", all_outs(), 64'd0);
    cyc();
    check("rst_held_outputs", all_outs(), 64'd0);
    #2;
    rst_n = 1'b1;
    cyc();
    check("rst_release_idle", {61'd0, busy_o, rready_o, bready_o}, 64'h3);

    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_7008;
    mem_be_i = 4'b0011; mem_wdata_i = 32'h0000_ABCD;
    settle();
    check("post_rst_gnt", {63'd0, mem_gnt_o}, 64'd1);
    cyc();
    mem_req_i = 1'b0;
    check("post_rst_aw", {30'd0, awvalid_o, wvalid_o, awaddr_o}, {30'd0, 2'b11, 32'h0000_7008});
    awready_i = 1'b1; wready_i = 1'b1;
    cyc();
    awready_i = 1'b0; wready_i = 1'b0;
    bvalid_i = 1'b1; bresp_i = 2'b00;
    cyc();
    bvalid_i = 1'b0;
    check("post_rst_done", {62'd0, mem_rvalid_o, mem_err_o}, 64'h2);
    cyc();
    check("post_rst_idle", {62'd0, mem_rvalid_o, busy_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
